// File: rtl/sl_access_ctrl.sv
// Initiator-side sequencer for the 8-lane source-line converter: runs ADC settle/latch/scan
// and DAC latch/hold timing per request. Optional SL_SAT_FLAG_EN adds per-lane rail flags.
module sl_access_ctrl #(
  parameter int SETTLE_CYC = 4,
  parameter int LOCK_CYC   = 2,
  parameter int HOLD_CYC   = 8,
  parameter int CNT_W      = 8
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_write,
  output logic [63:0] rsp_data,
  output logic        read_mode,
  output logic        adc_lock_en,
  output logic        dac_lock_en,
  output logic [7:0]  digital_data,
  output logic [2:0]  addr,
`ifdef SL_SAT_FLAG_EN
  output logic [7:0]  rsp_sat,
`endif
  input  logic [7:0]  digital_read
);

  localparam int SettleN = (SETTLE_CYC < 1) ? 1 : SETTLE_CYC;
  localparam int LockN   = (LOCK_CYC < 1) ? 1 : LOCK_CYC;
  localparam int HoldN   = (HOLD_CYC < 1) ? 1 : HOLD_CYC;

  localparam logic [CNT_W-1:0] SettleLast = CNT_W'(SettleN - 1);
  localparam logic [CNT_W-1:0] LockLast   = CNT_W'(LockN - 1);
  localparam logic [CNT_W-1:0] HoldLast   = CNT_W'(HoldN - 1);
  localparam logic [CNT_W-1:0] ScanLast   = CNT_W'(7);

  typedef enum logic [2:0] {
    StIdle, StRdSettle, StRdLock, StRdScan, StWrLock, StWrHold, StResp
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              wr_q, wr_d;
  logic [63:0]       rd_buf_q, rd_buf_d;
  logic              rsp_load;

  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_write_q, rsp_write_d;
  logic [63:0]       rsp_data_q, rsp_data_d;
  logic              read_mode_q, read_mode_d;
  logic              adc_lock_q, adc_lock_d;
  logic              dac_lock_q, dac_lock_d;
  logic [7:0]        dd_q, dd_d;
  logic [2:0]        addr_q, addr_d;
  logic [7:0]        sat_q, sat_d, sat_calc;

  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    dd_d    = dd_q;
    case (state_q)
      StIdle: begin
        if (req_valid) begin
          wr_d = req_write;
          if (req_write) begin
            state_d = StWrLock;
            dd_d    = req_wdata;
          end else begin
            state_d = StRdSettle;
          end
        end
      end
      StRdSettle: if (cnt_q == SettleLast) state_d = StRdLock;
      StRdLock:   if (cnt_q == LockLast)   state_d = StRdScan;
      StRdScan:   if (cnt_q == ScanLast)   state_d = StResp;
      StWrLock:   if (cnt_q == LockLast)   state_d = StWrHold;
      StWrHold:   if (cnt_q == HoldLast)   state_d = StResp;
      StResp:     if (rsp_ready)           state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  // Counter is held at zero in the untimed states so it can never wrap while waiting.
  always_comb begin
    if ((state_d != state_q) || (state_d == StIdle) || (state_d == StResp)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // digital_read follows addr combinationally, so the byte for lane addr_q is valid now.
  always_comb begin
    rd_buf_d = rd_buf_q;
    if (state_q == StRdScan) begin
      for (int k = 0; k < 8; k++) begin
        if (addr_q == 3'(k)) rd_buf_d[8*k +: 8] = digital_read;
      end
    end
  end

  always_comb begin
    sat_calc = '0;
    for (int k = 0; k < 8; k++) begin
      sat_calc[k] = (rd_buf_d[8*k +: 8] == 8'hFF) || (rd_buf_d[8*k +: 8] == 8'h00);
    end
  end

  always_comb begin
    rsp_load    = (state_d == StResp) && (state_q != StResp);
    req_ready_d = (state_d == StIdle);
    rsp_valid_d = (state_d == StResp);
    read_mode_d = (state_d == StRdSettle) || (state_d == StRdLock) || (state_d == StRdScan);
    adc_lock_d  = (state_d == StRdLock);
    dac_lock_d  = (state_d == StWrLock);
    addr_d      = (state_d == StRdScan) ? cnt_d[2:0] : 3'd0;
    rsp_data_d  = rsp_data_q;
    rsp_write_d = rsp_write_q;
    sat_d       = sat_q;
    if (rsp_load) begin
      rsp_write_d = wr_q;
      rsp_data_d  = wr_q ? 64'h0 : rd_buf_d;
      sat_d       = wr_q ? 8'h0 : sat_calc;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      wr_q        <= 1'b0;
      rd_buf_q    <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_data_q  <= '0;
      read_mode_q <= 1'b0;
      adc_lock_q  <= 1'b0;
      dac_lock_q  <= 1'b0;
      dd_q        <= '0;
      addr_q      <= '0;
      sat_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_q        <= wr_d;
      rd_buf_q    <= rd_buf_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_data_q  <= rsp_data_d;
      read_mode_q <= read_mode_d;
      adc_lock_q  <= adc_lock_d;
      dac_lock_q  <= dac_lock_d;
      dd_q        <= dd_d;
      addr_q      <= addr_d;
      sat_q       <= sat_d;
    end
  end

  assign req_ready    = req_ready_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_write    = rsp_write_q;
  assign rsp_data     = rsp_data_q;
  assign read_mode    = read_mode_q;
  assign adc_lock_en  = adc_lock_q;
  assign dac_lock_en  = dac_lock_q;
  assign digital_data = dd_q;
  assign addr         = addr_q;

`ifdef SL_SAT_FLAG_EN
  assign rsp_sat = sat_q;
`else
  logic unused_sat;
  assign unused_sat = ^sat_q;
`endif

endmodule

// File: tb/tb_sl_access_ctrl.sv
// Self-checking bench for sl_access_ctrl: transaction-level timeline model, directed
// scenarios and randomized read/write traffic with backpressure and mid-flight resets.
`timescale 1ns/1ps
module tb_sl_access_ctrl;

  localparam int S = 4;
  localparam int L = 2;
  localparam int H = 8;
  localparam int RdLat = S + L + 8;
  localparam int WrLat = L + H;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [7:0]  req_wdata = 8'h0;
  logic        rsp_ready = 1'b0;
  logic        req_ready, rsp_valid, rsp_write, read_mode, adc_lock_en, dac_lock_en;
  logic [63:0] rsp_data;
  logic [7:0]  digital_data, digital_read;
  logic [2:0]  addr;
`ifdef SL_SAT_FLAG_EN
  logic [7:0]  rsp_sat;
`endif
  logic [7:0]  lanes [8];

  assign digital_read = lanes[addr];
  always #5 sys_clk = ~sys_clk;

  sl_access_ctrl dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_write    (rsp_write),
    .rsp_data     (rsp_data),
    .read_mode    (read_mode),
    .adc_lock_en  (adc_lock_en),
    .dac_lock_en  (dac_lock_en),
    .digital_data (digital_data),
    .addr         (addr),
`ifdef SL_SAT_FLAG_EN
    .rsp_sat      (rsp_sat),
`endif
    .digital_read (digital_read)
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  bit chk_en = 1'b0;
  int rm_tot = 0, adc_tot = 0, dac_tot = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: a request is a timeline of cycles counted from its accept edge (cycle 1 follows it).
  bit          m_busy = 1'b0, m_resp = 1'b0, m_wr = 1'b0, m_rwr = 1'b0;
  int          m_c = 0;
  logic [7:0]  m_dd = 8'h0, m_sat = 8'h0;
  logic [63:0] m_data = 64'h0;

  function automatic logic [63:0] pack_lanes();
    logic [63:0] v;
    for (int k = 0; k < 8; k++) v[8*k +: 8] = lanes[k];
    return v;
  endfunction

  always @(posedge sys_clk) begin
    cyc = cyc + 1;
    if (sys_rst) begin
      m_busy = 1'b0; m_resp = 1'b0; m_dd = 8'h0; m_data = 64'h0; m_rwr = 1'b0; m_sat = 8'h0;
    end else if (m_resp) begin
      if (rsp_ready) m_resp = 1'b0;
    end else if (m_busy) begin
      m_c++;
      if (m_c == (m_wr ? WrLat : RdLat) + 1) begin
        m_busy = 1'b0;
        m_resp = 1'b1;
        m_rwr  = m_wr;
        m_data = m_wr ? 64'h0 : pack_lanes();
        m_sat  = 8'h0;
        if (!m_wr) for (int k = 0; k < 8; k++) m_sat[k] = (lanes[k] == 8'hFF) || (lanes[k] == 8'h00);
      end
    end else if (req_valid) begin
      m_busy = 1'b1;
      m_c    = 1;
      m_wr   = req_write;
      if (req_write) m_dd = req_wdata;
    end
  end

  always @(negedge sys_clk) begin
    bit rd;
    int ea;
    if (chk_en) begin
      rd = m_busy && !m_wr;
      ea = (rd && m_c > S + L) ? m_c - S - L - 1 : 0;
      chk("req_ready", 64'(req_ready), 64'(!m_busy && !m_resp));
      chk("rsp_valid", 64'(rsp_valid), 64'(m_resp));
      chk("read_mode", 64'(read_mode), 64'(rd));
      chk("adc_lock_en", 64'(adc_lock_en), 64'(rd && m_c > S && m_c <= S + L));
      chk("dac_lock_en", 64'(dac_lock_en), 64'(m_busy && m_wr && m_c <= L));
      chk("addr", 64'(addr), 64'(ea));
      chk("digital_data", 64'(digital_data), 64'(m_dd));
      if (m_resp) begin
        chk("rsp_data", rsp_data, m_data);
        chk("rsp_write", 64'(rsp_write), 64'(m_rwr));
`ifdef SL_SAT_FLAG_EN
        chk("rsp_sat", 64'(rsp_sat), 64'(m_sat));
`endif
      end
    end
    rm_tot  += int'(read_mode === 1'b1);
    adc_tot += int'(adc_lock_en === 1'b1);
    dac_tot += int'(dac_lock_en === 1'b1);
  end

  task automatic tick();
    @(negedge sys_clk);
    #1;
  endtask

  task automatic issue(input bit wr, input logic [7:0] wd, output int acc);
    int t = 0;
    while (req_ready !== 1'b1 && t < 50) begin tick(); t++; end
    if (req_ready !== 1'b1) chk("req_ready_wait", 64'(req_ready), 64'd1);
    req_valid = 1'b1;
    req_write = wr;
    req_wdata = wd;
    tick();
    acc = cyc;
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int acc, input int lat);
    int t = 0;
    while (rsp_valid !== 1'b1 && t < 60) begin tick(); t++; end
    chk("latency", 64'(cyc - acc), 64'(lat));
  endtask

  task automatic finish_rsp(input int delay);
    repeat (delay) tick();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int acc, rm0, adc0, dac0;
    for (int k = 0; k < 8; k++) lanes[k] = 8'h0;
    tick();
    chk_en = 1'b1;
    tick(); tick();
    sys_rst = 1'b0;
    repeat (5) tick();
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_outputs", {56'h0, read_mode, adc_lock_en, dac_lock_en, addr, 2'b0}, 64'h0);
    chk("rst_digital_data", 64'(digital_data), 64'h0);
    chk("rst_rsp_data", rsp_data, 64'h0);

    // Directed read, lane k returns 8'h10+k.
    for (int k = 0; k < 8; k++) lanes[k] = 8'(8'h10 + k);
    rm0 = rm_tot; adc0 = adc_tot;
    issue(1'b0, 8'h00, acc);
    wait_rsp(acc, 14);
    chk("rd_read_mode_cycles", 64'(rm_tot - rm0), 64'd14);
    chk("rd_adc_lock_cycles", 64'(adc_tot - adc0), 64'd2);
    chk("rd_rsp_data", rsp_data, 64'h17161514_13121110);
    chk("rd_rsp_write", 64'(rsp_write), 64'd0);
    finish_rsp(0);

    // Directed write of 8'hA5.
    dac0 = dac_tot; rm0 = rm_tot;
    issue(1'b1, 8'hA5, acc);
    chk("wr_dd_during_lock", 64'(digital_data), 64'hA5);
    wait_rsp(acc, 10);
    chk("wr_dac_lock_cycles", 64'(dac_tot - dac0), 64'd2);
    chk("wr_read_mode_cycles", 64'(rm_tot - rm0), 64'd0);
    chk("wr_rsp_data", rsp_data, 64'h0);
    chk("wr_rsp_write", 64'(rsp_write), 64'd1);
    finish_rsp(0);
    tick();
    chk("wr_dd_kept", 64'(digital_data), 64'hA5);

    // Backpressure with a pending request behind it.
    for (int k = 0; k < 8; k++) lanes[k] = 8'($urandom);
    issue(1'b0, 8'h00, acc);
    wait_rsp(acc, RdLat);
    req_valid = 1'b1; req_write = 1'b1; req_wdata = 8'h3C;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("bp_rsp_data", rsp_data, pack_lanes());
      chk("bp_req_ready", 64'(req_ready), 64'd0);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("bp_bubble_ready", 64'(req_ready), 64'd1);
    chk("bp_bubble_valid", 64'(rsp_valid), 64'd0);
    tick();
    acc = cyc;
    req_valid = 1'b0;
    chk("bp_accepted", 64'(dac_lock_en), 64'd1);
    wait_rsp(acc, WrLat);
    finish_rsp(0);

    // Reset during the ADC latch window.
    issue(1'b0, 8'h00, acc);
    repeat (S) tick();
    chk("rl_in_lock", 64'(adc_lock_en), 64'd1);
    sys_rst = 1'b1;
    tick();
    sys_rst = 1'b0;
    chk("rl_outputs", {54'h0, rsp_valid, read_mode, adc_lock_en, dac_lock_en, addr, 2'b0}, 64'h0);
    chk("rl_digital_data", 64'(digital_data), 64'h0);
    chk("rl_req_ready", 64'(req_ready), 64'd1);
    issue(1'b1, 8'h5A, acc);
    wait_rsp(acc, WrLat);
    chk("rl_wr_rsp_write", 64'(rsp_write), 64'd1);
    finish_rsp(1);

`ifdef SL_SAT_FLAG_EN
    lanes[0] = 8'hFF; lanes[1] = 8'h00; lanes[2] = 8'h7F; lanes[3] = 8'h80;
    lanes[4] = 8'hFF; lanes[5] = 8'h01; lanes[6] = 8'hFE; lanes[7] = 8'h00;
    issue(1'b0, 8'h00, acc);
    wait_rsp(acc, RdLat);
    chk("sat_flags", 64'(rsp_sat), 64'b1001_0011);
    finish_rsp(0);
`endif

    // Randomized traffic.
    for (int i = 0; i < 40; i++) begin
      bit wr;
      logic [7:0] wd;
      wr = 1'($urandom_range(0, 1));
      wd = 8'($urandom);
      for (int k = 0; k < 8; k++) lanes[k] = 8'($urandom);
      issue(wr, wd, acc);
      if ($urandom_range(0, 7) == 0) begin
        repeat ($urandom_range(0, 9)) tick();
        sys_rst = 1'b1;
        tick();
        sys_rst = 1'b0;
      end else begin
        wait_rsp(acc, wr ? WrLat : RdLat);
        finish_rsp(int'($urandom_range(0, 3)));
      end
    end
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sl_access_ctrl.md
Name: sl_access_ctrl

Overview:
- Initiator-side sequencer that drives the 8-lane source-line converter interface (read_mode, adc_lock_en, dac_lock_en, digital_data, addr) and collects its digital_read bytes.
- Accepts single read/write requests from the array control logic over a valid/ready handshake.
- Runs the converter's latch/settle/scan timing.
- Returns one 64-bit response per request: eight ADC bytes for a read, zero for a write.

Parameters:
- SETTLE_CYC, 4, cycles read_mode is held before the ADC latch opens (values <1 treated as 1)
- LOCK_CYC, 2, cycles adc_lock_en / dac_lock_en is held high (values <1 treated as 1)
- HOLD_CYC, 8, cycles the DAC value is held on the bus after latching, before completion (values <1 treated as 1)
- CNT_W, 8, width of the internal delay counter; must hold max(SETTLE_CYC, LOCK_CYC, HOLD_CYC)

Ports:
- sys_clk  in  1  single clock
- sys_rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when valid&&ready
- req_write  in  1  1 = DAC write, 0 = ADC read
- req_wdata  in  8  DAC code for a write
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when valid&&ready
- rsp_write  out  1  echo of req_write
- rsp_data  out  64  byte k in bits [8k+7:8k] = lane k ADC code; 0 for writes
- read_mode  out  1  to converter
- adc_lock_en  out  1  to converter ADC latch
- dac_lock_en  out  1  to converter DAC latch
- digital_data  out  8  to converter DAC input
- addr  out  3  lane select to converter
- digital_read  in  8  converter byte for lane addr (combinational from addr)

Behaviour:
- All outputs are registered. Reset value of every output is 0, except req_ready, which is 1 in IDLE after reset.
- States: IDLE, RD_SETTLE, RD_LOCK, RD_SCAN, WR_LOCK, WR_HOLD, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, capture req_write/req_wdata and clear the counter.
  - Go to RD_SETTLE (read) or WR_LOCK (write).
  - req_ready=0 in every other state; req_valid is ignored while busy.
- RD_SETTLE: read_mode=1 for SETTLE_CYC cycles, then RD_LOCK.
- RD_LOCK: read_mode=1, adc_lock_en=1 for LOCK_CYC cycles, then RD_SCAN.
- RD_SCAN:
  - read_mode=1, adc_lock_en=0.
  - addr steps 0..7, one lane per cycle.
  - At the edge ending the cycle with addr==k, digital_read is stored into byte k.
  - After k=7, go to RESP; addr returns to 0.
- WR_LOCK:
  - read_mode=0, digital_data=captured wdata, dac_lock_en=1 for LOCK_CYC cycles.
  - Then WR_HOLD.
- WR_HOLD: dac_lock_en=0, digital_data held, for HOLD_CYC cycles, then RESP.
- digital_data keeps its last written value after the write until the next write or reset.
- RESP:
  - read_mode=0, rsp_valid=1; rsp_data and rsp_write stable until rsp_ready.
  - Handshake returns to IDLE on the next edge.
  - req_valid asserted in the same cycle is not accepted until IDLE (one bubble cycle).
- Latency from accept edge to rsp_valid high:
  - read: SETTLE_CYC+LOCK_CYC+8 edges (14 at defaults)
  - write: LOCK_CYC+HOLD_CYC edges (10 at defaults)
- rsp_data for writes is 64'h0. rsp_data for reads fully overwrites the previous response.
- Reset mid-operation: next edge returns to IDLE and all outputs go to reset values. The in-flight request is dropped with no response, and lock enables drop immediately.
- Counter counts 0..N-1 and clears on every state change; it never wraps within a state.

Optional Feature:
- Macro SL_SAT_FLAG_EN.
- Defined:
  - Extra output port rsp_sat (8 bits).
  - Bit k is set when byte k of a read equals 8'hFF or 8'h00 (rail-clipped lane); valid with rsp_valid.
  - Forced 0 for writes; reset value 0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then idle 5 cycles -> req_ready=1, rsp_valid=0, read_mode=0, adc_lock_en=0, dac_lock_en=0, addr=0, digital_data=0.
- Read request with converter model returning 8'h10+k on lane k:
  - read_mode high 14 cycles, adc_lock_en high exactly 2 cycles after 4.
  - addr sequence 0..7.
  - rsp_valid 14 edges after accept, rsp_data=64'h17161514_13121110, rsp_write=0.
- Write req_wdata=8'hA5:
  - dac_lock_en high exactly 2 cycles with digital_data=8'hA5 and read_mode=0.
  - rsp_valid 10 edges after accept, rsp_data=0, rsp_write=1, digital_data stays 8'hA5.
- Response backpressure: hold rsp_ready=0 for 6 cycles while req_valid=1 -> rsp_data stable, req_ready=0; after rsp_ready, the new request is accepted one cycle later.
- Assert sys_rst during RD_LOCK -> next edge all outputs 0, no rsp_valid. A following write completes normally.
- With SL_SAT_FLAG_EN, lanes returning {FF,00,7F,80,FF,01,FE,00} -> rsp_sat=8'b1001_0011 (bit0=lane0).
